// File: rtl/scan_fault_decoder.sv
// Walking-zero scan fault decoder: emits one OPEN/SHORT record per mismatched pin.
// Optional saturating record counter enabled by SCAN_FAULT_CNT_EN.
module scan_fault_decoder #(
    parameter int N_PAIR = 86,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_valid,
    output logic              scan_ready,
    input  logic [IDX_W-1:0]  scan_step,
    input  logic [N_PAIR-1:0] scan_exp,
    input  logic [N_PAIR-1:0] scan_obs,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [IDX_W-1:0]  rec_step,
    output logic [IDX_W-1:0]  rec_pin,
    output logic              rec_type,
    output logic              any_fault,
    output logic [15:0]       fault_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_step;
    logic [N_PAIR-1:0] r_exp;
    logic [N_PAIR-1:0] r_diff;
    logic              r_any;

    logic [N_PAIR-1:0] w_diff_in;
    logic [N_PAIR-1:0] w_onehot;
    logic [N_PAIR-1:0] w_diff_clr;
    logic [IDX_W-1:0]  w_pin;
    logic              w_scan_fire;
    logic              w_rec_fire;

    assign scan_ready  = (r_state == S_IDLE) && !reset;
    assign rec_valid   = (r_state == S_EMIT) && !reset;
    assign w_scan_fire = scan_valid && scan_ready;
    assign w_rec_fire  = rec_valid && rec_ready;
    assign w_diff_in   = scan_exp ^ scan_obs;

    // Isolate the lowest pending mismatch; it is both the record and the bit to clear.
    assign w_onehot   = r_diff & (~r_diff + N_PAIR'(1));
    assign w_diff_clr = r_diff & ~w_onehot;

    always_comb begin
        w_pin = '0;
        for (int i = N_PAIR - 1; i >= 0; i--) begin
            if (r_diff[i]) begin
                w_pin = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_scan_fire && (|w_diff_in)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_rec_fire && !(|w_diff_clr)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
            r_exp  <= '0;
            r_diff <= '0;
        end else if (w_scan_fire) begin
            r_step <= scan_step;
            r_exp  <= scan_exp;
            r_diff <= w_diff_in;
        end else if (w_rec_fire) begin
            r_diff <= w_diff_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_any <= 1'b0;
        end else if (w_rec_fire) begin
            r_any <= 1'b1;
        end
    end

    assign rec_step  = reset ? '0 : r_step;
    assign rec_pin   = reset ? '0 : w_pin;
    assign rec_type  = !reset && (|(r_exp & w_onehot));
    assign any_fault = r_any;

`ifdef SCAN_FAULT_CNT_EN
    logic [15:0] r_fault_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_cnt <= '0;
        end else if (w_rec_fire && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    assign fault_cnt = r_fault_cnt;
`else
    assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_scan_fault_decoder.sv
// Directed bench for scan_fault_decoder: vector table plus backpressure,
// reset-mid-emit and (with SCAN_FAULT_CNT_EN) counter saturation sequences.
module tb_scan_fault_decoder;

    localparam int NP = 86;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          scan_valid;
    logic          scan_ready;
    logic [IW-1:0] scan_step;
    logic [NP-1:0] scan_exp;
    logic [NP-1:0] scan_obs;
    logic          rec_valid;
    logic          rec_ready;
    logic [IW-1:0] rec_step;
    logic [IW-1:0] rec_pin;
    logic          rec_type;
    logic          any_fault;
    logic [15:0]   fault_cnt;

    scan_fault_decoder #(.N_PAIR(NP), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_step  (scan_step),
        .scan_exp   (scan_exp),
        .scan_obs   (scan_obs),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_step   (rec_step),
        .rec_pin    (rec_pin),
        .rec_type   (rec_type),
        .any_fault  (any_fault),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]       step;
        logic [NP-1:0]       exp;
        logic [NP-1:0]       obs;
        logic [1:0]          n;
        logic [2:0][IW-1:0]  pin;
        logic [2:0]          typ;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic        e_any;
    logic [15:0] e_cnt;
    vec_t        tbl[5];
    vec_t        v3;
    vec_t        vsh;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int step, input logic [NP-1:0] e,
                                input logic [NP-1:0] o, input int n,
                                input int p0, input int t0, input int p1,
                                input int t1, input int p2, input int t2);
        vec_t r;
        r.step   = IW'(step);
        r.exp    = e;
        r.obs    = o;
        r.n      = 2'(n);
        r.pin[0] = IW'(p0);
        r.pin[1] = IW'(p1);
        r.pin[2] = IW'(p2);
        r.typ[0] = t0[0];
        r.typ[1] = t1[0];
        r.typ[2] = t2[0];
        return r;
    endfunction

    function automatic logic [NP-1:0] bit1(input int i);
        logic [NP-1:0] one;
        one = NP'(1);
        return one << i;
    endfunction

    // One accepted handshake in the reference model.
    task automatic model_rec();
        e_any = 1'b1;
`ifdef SCAN_FAULT_CNT_EN
        if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
    endtask

    task automatic offer(input vec_t t);
        @(negedge clk);
        chk("accept_ready", 32'(scan_ready), 32'd1);
        scan_valid = 1'b1;
        scan_step  = t.step;
        scan_exp   = t.exp;
        scan_obs   = t.obs;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        rec_ready = 1'b1;
        offer(t);
        for (int k = 0; k < int'(t.n); k++) begin
            chk("rec_valid", 32'(rec_valid), 32'd1);
            chk("rec_step", 32'(rec_step), 32'(t.step));
            chk("rec_pin", 32'(rec_pin), 32'(t.pin[k]));
            chk("rec_type", 32'(rec_type), 32'(t.typ[k]));
            chk("scan_ready_emit", 32'(scan_ready), 32'd0);
            model_rec();
            @(negedge clk);
        end
        chk("done_valid", 32'(rec_valid), 32'd0);
        chk("done_ready", 32'(scan_ready), 32'd1);
        chk("any_fault", 32'(any_fault), 32'(e_any));
        chk("fault_cnt", 32'(fault_cnt), 32'(e_cnt));
    endtask

    initial begin
        logic [NP-1:0] ones;
        ones = '1;
        e_any = 1'b0;
        e_cnt = '0;
        tbl[0] = mk(5, ~bit1(5), ~bit1(5), 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(3, ~bit1(3), ones, 1, 3, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, ~bit1(0), ~(bit1(0) | bit1(10) | bit1(85)),
                    2, 10, 1, 85, 1, 0, 0);
        tbl[3] = mk(7, ~bit1(7), ~bit1(2), 2, 2, 1, 7, 0, 0, 0);
        tbl[4] = mk(85, ~bit1(85), ones, 1, 85, 0, 0, 0, 0, 0);
        v3  = mk(9, ~bit1(9), ~(bit1(1) | bit1(4)), 3, 1, 1, 4, 1, 9, 0);
        vsh = tbl[2];

        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_step  = '0;
        scan_exp   = '0;
        scan_obs   = '0;
        rec_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scan_ready", 32'(scan_ready), 32'd0);
        chk("rst_rec_valid", 32'(rec_valid), 32'd0);
        chk("rst_rec_pin", 32'(rec_pin), 32'd0);
        chk("rst_any", 32'(any_fault), 32'd0);
        chk("rst_cnt", 32'(fault_cnt), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(scan_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i]);
        end

        // Backpressure: hold the first short for 4 cycles, offer a new scan meanwhile.
        rec_ready = 1'b0;
        offer(vsh);
        scan_valid = 1'b1;
        scan_step  = 7'd42;
        scan_exp   = ~bit1(42);
        scan_obs   = ones;
        for (int c = 0; c < 4; c++) begin
            chk("bp_valid", 32'(rec_valid), 32'd1);
            chk("bp_step", 32'(rec_step), 32'd0);
            chk("bp_pin", 32'(rec_pin), 32'd10);
            chk("bp_type", 32'(rec_type), 32'd1);
            chk("bp_scan_ready", 32'(scan_ready), 32'd0);
            @(negedge clk);
        end
        scan_valid = 1'b0;
        rec_ready  = 1'b1;
        chk("bp_pin_a", 32'(rec_pin), 32'd10);
        model_rec();
        @(negedge clk);
        chk("bp_pin_b", 32'(rec_pin), 32'd85);
        chk("bp_step_b", 32'(rec_step), 32'd0);
        model_rec();
        @(negedge clk);
        chk("bp_idle_valid", 32'(rec_valid), 32'd0);
        chk("bp_idle_ready", 32'(scan_ready), 32'd1);
        chk("bp_cnt", 32'(fault_cnt), 32'(e_cnt));

        // Reset after the first of three records.
        rec_ready = 1'b1;
        offer(v3);
        chk("mr_pin0", 32'(rec_pin), 32'd1);
        @(negedge clk);
        chk("mr_pin1", 32'(rec_pin), 32'd4);
        reset = 1'b1;
        #1;
        chk("mr_rst_valid", 32'(rec_valid), 32'd0);
        chk("mr_rst_ready", 32'(scan_ready), 32'd0);
        @(negedge clk);
        e_any = 1'b0;
        e_cnt = '0;
        chk("mr_any", 32'(any_fault), 32'd0);
        chk("mr_cnt", 32'(fault_cnt), 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mr_post_ready", 32'(scan_ready), 32'd1);
            chk("mr_post_valid", 32'(rec_valid), 32'd0);
            @(negedge clk);
        end
        chk("mr_cnt_after", 32'(fault_cnt), 32'd0);

`ifdef SCAN_FAULT_CNT_EN
        dut.r_fault_cnt = 16'hFFFE;
        e_cnt = 16'hFFFE;
        run_vec(v3);
        chk("sat_cnt", 32'(fault_cnt), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_fault_decoder.md
SCAN_FAULT_DECODER -- requirements
Module: scan_fault_decoder

Interface
REQ-001 SHALL have parameter N_PAIR, default 86: number of scanned pin pairs.
REQ-002 SHALL have parameter IDX_W, default 7: width of pin and step indices; requires 2**IDX_W >= N_PAIR.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port scan_valid, input, 1: a scan step sample is offered.
REQ-006 SHALL have port scan_ready, output, 1: the block can accept a sample.
REQ-007 SHALL have port scan_step, input, IDX_W: index of the driven-low pair for this step.
REQ-008 SHALL have port scan_exp, input, N_PAIR: expected pattern, single 0 walking in 1s.
REQ-009 SHALL have port scan_obs, input, N_PAIR: registered readback of the input pins.
REQ-010 SHALL have port rec_valid, output, 1: a fault record is presented.
REQ-011 SHALL have port rec_ready, input, 1: the downstream consumer accepts the record.
REQ-012 SHALL have port rec_step, output, IDX_W: step index of the record.
REQ-013 SHALL have port rec_pin, output, IDX_W: failing pair index, 0 = LSB of scan vectors.
REQ-014 SHALL have port rec_type, output, 1: 0 = OPEN, 1 = SHORT.
REQ-015 SHALL have port any_fault, output, 1: sticky flag, set once any record has been emitted.
REQ-016 SHALL have port fault_cnt, output, 16: count of emitted records (see Configuration).

Function
REQ-017 SHALL implement two states, IDLE and EMIT; scan_ready = 1 only in IDLE.
REQ-018 SHALL, on scan_valid && scan_ready, latch scan_step, scan_exp and diff = scan_exp ^ scan_obs.
REQ-019 SHALL, at acceptance, go to EMIT if diff != 0; if diff == 0, SHALL stay in IDLE and emit nothing.
REQ-020 SHALL, in EMIT, assert rec_valid with rec_pin = index of the lowest set bit of the remaining diff.
REQ-021 SHALL present the first record in the cycle after acceptance (latency 1).
REQ-022 SHALL set rec_type = 0 (OPEN) when the latched exp bit at rec_pin is 0 and = 1 (SHORT) when it is 1.
REQ-023 SHALL hold rec_valid, rec_step, rec_pin and rec_type stable until rec_valid && rec_ready.
REQ-024 SHALL, on rec_valid && rec_ready, clear that diff bit; if the remaining diff is 0, SHALL return to IDLE in the next cycle.
REQ-025 SHALL emit exactly popcount(diff) records per step, in ascending pin order, sustaining one per cycle while rec_ready = 1.
REQ-026 SHALL keep scan_ready = 0 while in EMIT, so a scan_valid offered then is not accepted.
REQ-027 SHALL set any_fault in the cycle after the first record handshake; it clears only on reset.
REQ-028 SHALL treat diff bits at positions >= N_PAIR as nonexistent.

Reset
REQ-029 SHALL, while reset = 1, force: state IDLE, scan_ready 0, rec_valid 0, rec_step/rec_pin/rec_type 0, any_fault 0, fault_cnt 0, latched vectors 0.
REQ-030 SHALL assert scan_ready = 1 in the first cycle after reset deasserts.
REQ-031 SHALL discard pending records when reset asserts mid-EMIT; no record is emitted after reset.

Configuration
REQ-032 SHALL, with SCAN_FAULT_CNT_EN defined, increment fault_cnt by 1 per record handshake, saturating at 16'hFFFF.
REQ-033 SHALL, with SCAN_FAULT_CNT_EN undefined, drive fault_cnt to constant 0 with no counter logic; the port remains.

Verification
REQ-034 SHALL cover a clean step: exp = obs = ~(1<<5), step 5 -> no rec_valid, scan_ready high the next cycle, any_fault 0.
REQ-035 SHALL cover an open: exp = ~(1<<3), obs = all 1s, step 3 -> one record {step 3, pin 3, OPEN} one cycle after acceptance.
REQ-036 SHALL cover shorts: exp = ~(1<<0), obs = ~(1<<0 | 1<<10 | 1<<85), rec_ready = 1 -> records pin 10 SHORT then pin 85 SHORT on consecutive cycles, then IDLE.
REQ-037 SHALL cover backpressure: rec_ready held low for 4 cycles with a record pending -> record fields stable, scan_valid offered then not accepted.
REQ-038 SHALL cover reset mid-EMIT: reset asserted after 1 of 3 records -> no further records, fault_cnt = 0, scan_ready = 1 after release.
REQ-039 SHALL cover saturation with SCAN_FAULT_CNT_EN defined: fault_cnt preloaded to 16'hFFFE, 3 records -> fault_cnt ends at 16'hFFFF.
